// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - XGMII control characters, TX encoder state codes and keep helper
package mac_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_TERM = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;
    localparam logic [2:0] ST_IPG  = 3'd5;

    // Number of leading ones from bit 7; a non-contiguous keep stops at the first hole.
    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] n;
        logic       run;
        n   = 4'd0;
        run = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (run && keep[i]) begin
                n = n + 4'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/crc32_d64.sv
// rtl/crc32_d64.sv - reflected CRC-32 step over the first nbytes_i bytes (byte 7 first)
module crc32_d64 (
    input  logic [31:0] crc_i,
    input  logic [63:0] data_i,
    input  logic [3:0]  nbytes_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_i;
        fb = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                if (b < int'(nbytes_i)) begin
                    fb = c[0] ^ data_i[56 - 8*b + i];
                    c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
                end
            end
        end
    end

    assign crc_o = c;

endmodule

// File: rtl/xgmii_tx_encoder.sv
// rtl/xgmii_tx_encoder.sv - AXI-stream to XGMII TX framing; XGMII_TX_FCS_EN appends CRC-32 FCS
module xgmii_tx_encoder
    import mac_pkg::*;
#(
    parameter int MIN_IPG_BYTES = 12
) (
    input  logic        i_xgmii_clk,
    input  logic        i_xgmii_rst,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] o_xgmii_txd,
    output logic [7:0]  o_xgmii_txc,
    output logic        o_tx_underrun
);

    logic [2:0]   state_q, state_d;
    logic [63:0]  txd_q, txd_d, hold_txd_q, hold_txd_d;
    logic [7:0]   txc_q, txc_d, hold_txc_q, hold_txc_d;
    logic         tready_q, tready_d, undr_q, undr_d, drop_q, drop_d;
    logic [2:0]   ipg_q, ipg_d;
    logic [3:0]   last_k;
    logic [31:0]  fcs, fcs_sh;
    logic [127:0] dpad, tail_d;
    logic [15:0]  tail_c;

    function automatic logic [2:0] ipg_cycles(input int idle_bytes);
        int d;
        d = MIN_IPG_BYTES - idle_bytes;
        return (d <= 0) ? 3'd0 : 3'((d + 7) / 8);
    endfunction

    assign last_k = keep_count(s_axis_tkeep);
    assign dpad   = {s_axis_tdata, 64'h0};

`ifdef XGMII_TX_FCS_EN
    localparam int FCS_BYTES = 4;
    logic [31:0] crc_q, crc_next;

    crc32_d64 u_crc (
        .crc_i    (crc_q),
        .data_i   (s_axis_tdata),
        .nbytes_i (s_axis_tlast ? last_k : 4'd8),
        .crc_o    (crc_next)
    );
    assign fcs = ~crc_next;

    always_ff @(posedge i_xgmii_clk or posedge i_xgmii_rst) begin
        if (i_xgmii_rst) begin
            crc_q <= '1;
        end else if (state_q == ST_PRE) begin
            crc_q <= '1;
        end else if (s_axis_tvalid && tready_q) begin
            crc_q <= crc_next;
        end
    end
`else
    localparam int FCS_BYTES = 0;
    assign fcs = 32'h0;
`endif

    // Last beat as a 16-lane wire-order tail: data, FCS, FD, then idles.
    always_comb begin
        int k;
        k      = int'(last_k);
        tail_d = '0;
        tail_c = '0;
        fcs_sh = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < k) begin
                tail_d[127-8*j -: 8] = dpad[127-8*j -: 8];
            end else if (j < k + FCS_BYTES) begin
                fcs_sh = fcs >> (8 * (j - k));
                tail_d[127-8*j -: 8] = fcs_sh[7:0];
            end else if (j == k + FCS_BYTES) begin
                tail_d[127-8*j -: 8] = XGMII_TERM;
                tail_c[15-j]         = 1'b1;
            end else begin
                tail_d[127-8*j -: 8] = XGMII_IDLE;
                tail_c[15-j]         = 1'b1;
            end
        end
    end

    always_comb begin
        int len;
        len        = int'(last_k) + FCS_BYTES + 1;
        state_d    = state_q;
        txd_d      = {8{XGMII_IDLE}};
        txc_d      = 8'hFF;
        hold_txd_d = hold_txd_q;
        hold_txc_d = hold_txc_q;
        ipg_d      = ipg_q;
        drop_d     = drop_q;
        undr_d     = 1'b0;
        case (state_q)
            ST_IDLE: if (s_axis_tvalid) state_d = ST_PRE;
            ST_PRE: begin
                txd_d   = {XGMII_START, {6{XGMII_PRE}}, XGMII_SFD};
                txc_d   = 8'h80;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!s_axis_tvalid) begin
                    txd_d      = {8{XGMII_ERROR}};
                    undr_d     = 1'b1;
                    hold_txd_d = {XGMII_TERM, {7{XGMII_IDLE}}};
                    hold_txc_d = 8'hFF;
                    drop_d     = 1'b1;
                    ipg_d      = ipg_cycles(7);
                    state_d    = ST_TERM;
                end else if (!s_axis_tlast) begin
                    txd_d = s_axis_tdata;
                    txc_d = 8'h00;
                end else begin
                    txd_d      = tail_d[127:64];
                    txc_d      = tail_c[15:8];
                    hold_txd_d = tail_d[63:0];
                    hold_txc_d = tail_c[7:0];
                    drop_d     = 1'b0;
                    if (len <= 8) begin
                        ipg_d   = ipg_cycles(8 - len);
                        state_d = ST_IPG;
                    end else begin
                        ipg_d   = ipg_cycles(16 - len);
                        state_d = ST_TERM;
                    end
                end
            end
            ST_TERM: begin
                txd_d   = hold_txd_q;
                txc_d   = hold_txc_q;
                state_d = drop_q ? ST_DROP : ST_IPG;
            end
            ST_DROP: if (s_axis_tvalid && s_axis_tlast) state_d = ST_IPG;
            ST_IPG: begin
                // A waiting frame skips IDLE so the gap is not stretched by a word.
                if (ipg_q <= 3'd1) begin
                    state_d = s_axis_tvalid ? ST_PRE : ST_IDLE;
                end else begin
                    ipg_d = ipg_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tready_d = (state_d == ST_DATA) || (state_d == ST_DROP);

    always_ff @(posedge i_xgmii_clk or posedge i_xgmii_rst) begin
        if (i_xgmii_rst) begin
            state_q    <= ST_IDLE;
            txd_q      <= {8{XGMII_IDLE}};
            txc_q      <= 8'hFF;
            tready_q   <= 1'b0;
            undr_q     <= 1'b0;
            ipg_q      <= 3'd0;
            drop_q     <= 1'b0;
            hold_txd_q <= '0;
            hold_txc_q <= '0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            tready_q   <= tready_d;
            undr_q     <= undr_d;
            ipg_q      <= ipg_d;
            drop_q     <= drop_d;
            hold_txd_q <= hold_txd_d;
            hold_txc_q <= hold_txc_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign o_xgmii_txd   = txd_q;
    assign o_xgmii_txc   = txc_q;
    assign o_tx_underrun = undr_q;

endmodule

// File: tb/tb_xgmii_tx_encoder.sv
// tb/tb_xgmii_tx_encoder.sv - directed bench for xgmii_tx_encoder
module tb_xgmii_tx_encoder;

    localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;
    localparam logic [63:0] PRE_W  = 64'hFB55_5555_5555_55D5;
    localparam logic [63:0] FE_W   = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] FD_W   = 64'hFD07_0707_0707_0707;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] o_xgmii_txd;
    logic [7:0]  o_xgmii_txc;
    logic        o_tx_underrun;

    logic [72:0] capq[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          gap_q[$];
    int          fd_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_undr, n_fe, n_bad;
    logic        cap_en = 1'b0;

    int exp_gap[8] = '{14, 13, 12, 19, 18, 17, 16, 15};
    int exp_fd[8]  = '{6, 5, 4, 3, 2, 1, 0, 7};

    always #5 clk = ~clk;

    xgmii_tx_encoder #(.MIN_IPG_BYTES(12)) dut (
        .i_xgmii_clk   (clk),
        .i_xgmii_rst   (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .o_xgmii_txd   (o_xgmii_txd),
        .o_xgmii_txc   (o_xgmii_txc),
        .o_tx_underrun (o_tx_underrun)
    );

    always @(posedge clk) begin
        #1;
        if (cap_en) capq.push_back({o_tx_underrun, o_xgmii_txc, o_xgmii_txd});
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_capture();
        capq.delete();
        exp_q.delete();
        cap_en = 1'b1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] kp, input logic last);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = kp;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("beat_wait_timeout", 72'(n >= 40), 72'd0);
        @(negedge clk);
    endtask

    // drop_before >= 0 idles tvalid for one cycle before that beat index.
    task automatic send_frame(input int nbytes, input logic [7:0] base, input int drop_before);
        int nbeats, rem, k;
        logic [63:0] d;
        logic [7:0]  kp;
        nbeats = (nbytes + 7) / 8;
        for (int bi = 0; bi < nbeats; bi++) begin
            rem = nbytes - 8 * bi;
            k   = (rem > 8) ? 8 : rem;
            if (bi == drop_before) begin
                s_axis_tvalid = 1'b0;
                @(negedge clk);
            end
            d  = '0;
            kp = '0;
            for (int j = 0; j < k; j++) begin
                d[63-8*j -: 8] = base + 8'(8 * bi + j);
                kp[7-j] = 1'b1;
                if (drop_before < 0 || bi < drop_before) exp_q.push_back(base + 8'(8 * bi + j));
            end
            send_beat(d, kp, bi == nbeats - 1);
        end
    endtask

    task automatic analyze();
        logic        in_pre, in_data, seen_term;
        int          pre_n, idle_run;
        logic [72:0] e;
        logic [7:0]  b;
        logic        c;
        rx_q.delete(); gap_q.delete(); fd_q.delete();
        n_undr = 0; n_fe = 0; n_bad = 0;
        in_pre = 1'b0; in_data = 1'b0; seen_term = 1'b0; pre_n = 0; idle_run = 0;
        for (int w = 0; w < capq.size(); w++) begin
            e = capq[w];
            if (e[72]) n_undr++;
            for (int j = 0; j < 8; j++) begin
                b = e[63-8*j -: 8];
                c = e[71-j];
                if (in_pre) begin
                    if (c || b != ((pre_n == 6) ? 8'hD5 : 8'h55)) n_bad++;
                    pre_n++;
                    if (pre_n == 7) begin in_pre = 1'b0; in_data = 1'b1; end
                end else if (c && b == 8'hFB) begin
                    if (j != 0) n_bad++;
                    if (seen_term) gap_q.push_back(idle_run);
                    in_pre = 1'b1; pre_n = 0; seen_term = 1'b0;
                end else if (!c) begin
                    if (in_data) rx_q.push_back(b);
                    else n_bad++;
                end else if (b == 8'hFD) begin
                    in_data = 1'b0; seen_term = 1'b1; idle_run = 0;
                    fd_q.push_back(7 - j);
                end else if (b == 8'h07) begin
                    idle_run++;
                end else if (b == 8'hFE) begin
                    in_data = 1'b0; n_fe++;
                end else begin
                    n_bad++;
                end
            end
        end
    endtask

    function automatic int find_word(input logic [71:0] w);
        for (int i = 0; i < capq.size(); i++) if (capq[i][71:0] == w) return i;
        return -1;
    endfunction

    function automatic logic [71:0] word_at(input int i);
        if (i < 0 || i >= capq.size()) return 72'h0;
        return capq[i][71:0];
    endfunction

    task automatic compare_sb(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) mism++;
        check({tag, "_sb_len"}, 72'(rx_q.size()), 72'(exp_q.size()));
        check({tag, "_sb_bytes"}, 72'(mism), 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p, e, nonidle;
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", 72'(o_xgmii_txd), 72'(IDLE_W));
        check("rst_txc", 72'(o_xgmii_txc), 72'hFF);
        check("rst_tready", 72'(s_axis_tready), 72'd0);
        check("rst_underrun", 72'(o_tx_underrun), 72'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_tready", 72'(s_axis_tready), 72'd0);

        // 19-byte frame, last keep E0
        start_capture();
        send_frame(19, 8'h10, -1);
        s_axis_tvalid = 1'b0;
        repeat (8) @(negedge clk);
        analyze();
        p = find_word({8'h80, PRE_W});
        check("t1_pre_found", 72'(p >= 0), 72'd1);
        check("t1_w1", word_at(p + 1), {8'h00, 64'h1011_1213_1415_1617});
        check("t1_w2", word_at(p + 2), {8'h00, 64'h1819_1A1B_1C1D_1E1F});
        check("t1_w3", word_at(p + 3), {8'h1F, 64'h2021_22FD_0707_0707});
        check("t1_w4", word_at(p + 4), {8'hFF, IDLE_W});
        compare_sb("t1");

        // keep sweep k=1..8, back-to-back
        start_capture();
        for (int k = 1; k <= 8; k++) send_frame(8 + k, 8'(k * 32), -1);
        send_frame(16, 8'hF0, -1);
        s_axis_tvalid = 1'b0;
        repeat (10) @(negedge clk);
        analyze();
        check("sweep_gap_count", 72'(gap_q.size()), 72'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sweep_gap_k%0d", i + 1), 72'((i < gap_q.size()) ? gap_q[i] : -1), 72'(exp_gap[i]));
            check($sformatf("sweep_fd_k%0d", i + 1), 72'((i < fd_q.size()) ? fd_q[i] : -1), 72'(exp_fd[i]));
        end
        compare_sb("sweep");
        check("sweep_bad", 72'(n_bad), 72'd0);

        // underrun before beat 1, then a normal 12-byte frame
        start_capture();
        send_frame(32, 8'h40, 1);
        send_frame(12, 8'h80, -1);
        s_axis_tvalid = 1'b0;
        repeat (10) @(negedge clk);
        analyze();
        e = find_word({8'hFF, FE_W});
        check("ur_fe_found", 72'(e >= 0), 72'd1);
        check("ur_term_word", word_at(e + 1), {8'hFF, FD_W});
        check("ur_pulses", 72'(n_undr), 72'd1);
        check("ur_fe_bytes", 72'(n_fe), 72'd8);
        check("ur_fd_count", 72'(fd_q.size()), 72'd2);
        check("ur_next_fd", 72'((fd_q.size() > 1) ? fd_q[1] : -1), 72'd3);
        check("ur_bad", 72'(n_bad), 72'd0);
        compare_sb("ur");

        // reset asserted while in DATA
        s_axis_tdata = 64'hDEAD_BEEF_0123_4567; s_axis_tkeep = 8'hFF; s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b1;
        p = 0;
        while (!s_axis_tready && p < 40) begin
            @(negedge clk);
            p++;
        end
        check("rst_mid_reach_data", 72'(p < 40), 72'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_txd", 72'(o_xgmii_txd), 72'(IDLE_W));
        check("rst_mid_txc", 72'(o_xgmii_txc), 72'hFF);
        check("rst_mid_tready", 72'(s_axis_tready), 72'd0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start_capture();
        send_frame(10, 8'hA0, -1);
        s_axis_tvalid = 1'b0;
        repeat (8) @(negedge clk);
        analyze();
        p = find_word({8'h80, PRE_W});
        nonidle = 0;
        for (int i = 0; i < p; i++) if (word_at(i) != {8'hFF, IDLE_W}) nonidle++;
        check("rst_post_pre_found", 72'(p >= 0), 72'd1);
        check("rst_post_clean_lead", 72'(nonidle), 72'd0);
        check("rst_post_bad", 72'(n_bad), 72'd0);
        compare_sb("rst_post");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
